// File: rtl/minirisc_pkg.sv
// Shared miniRISC encodings: instruction classes, ALU opcodes, branch functs, issue FSM states.
package minirisc_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned FN_W  = 4;

  // Instruction classes delivered by decode
  localparam logic [OPC_W-1:0] OPC_ALU_R  = 3'd0;
  localparam logic [OPC_W-1:0] OPC_ALU_I  = 3'd1;
  localparam logic [OPC_W-1:0] OPC_MEM_LD = 3'd2;
  localparam logic [OPC_W-1:0] OPC_MEM_ST = 3'd3;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 3'd4;

  // ALU ALUOp encodings
  localparam logic [OP_W-1:0] ALU_PASS = 4'b0000;
  localparam logic [OP_W-1:0] ALU_ADDC = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SHRL = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SHRA = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SHLL = 4'b0110;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_DIFF = 4'b1001;
  localparam logic [OP_W-1:0] ALU_ILL  = 4'b1111;

  // ALU funct codes (ALU_R / ALU_I)
  localparam logic [FN_W-1:0] FN_ADD  = 4'd0;
  localparam logic [FN_W-1:0] FN_COMP = 4'd1;
  localparam logic [FN_W-1:0] FN_AND  = 4'd2;
  localparam logic [FN_W-1:0] FN_XOR  = 4'd3;
  localparam logic [FN_W-1:0] FN_SHLL = 4'd4;
  localparam logic [FN_W-1:0] FN_SHRL = 4'd5;
  localparam logic [FN_W-1:0] FN_SHRA = 4'd6;
  localparam logic [FN_W-1:0] FN_DIFF = 4'd7;

  // Branch funct codes
  localparam logic [FN_W-1:0] BR_B    = 4'd0;
  localparam logic [FN_W-1:0] BR_BLTZ = 4'd1;
  localparam logic [FN_W-1:0] BR_BZ   = 4'd2;
  localparam logic [FN_W-1:0] BR_BNZ  = 4'd3;
  localparam logic [FN_W-1:0] BR_BCY  = 4'd4;
  localparam logic [FN_W-1:0] BR_BNCY = 4'd5;
  localparam logic [FN_W-1:0] BR_BL   = 4'd6;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_e;

endpackage

// File: rtl/branch_cond.sv
// Flag-based branch resolution: funct plus architectural flags -> taken / link.
module branch_cond
  import minirisc_pkg::*;
#(
  parameter int unsigned FUNCT_W = 4
) (
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               flag_s_i,
  input  logic               flag_z_i,
  input  logic               flag_c_i,
  output logic               taken_c_o,
  output logic               link_c_o
);

  // Condition table; undefined functs resolve not-taken (caller flags them illegal)
  always_comb begin
    taken_c_o = 1'b0;
    link_c_o  = 1'b0;
    if (funct_i == FUNCT_W'(BR_B)) begin
      taken_c_o = 1'b1;
    end else if (funct_i == FUNCT_W'(BR_BLTZ)) begin
      taken_c_o = flag_s_i;
    end else if (funct_i == FUNCT_W'(BR_BZ)) begin
      taken_c_o = flag_z_i;
    end else if (funct_i == FUNCT_W'(BR_BNZ)) begin
      taken_c_o = ~flag_z_i;
    end else if (funct_i == FUNCT_W'(BR_BCY)) begin
      taken_c_o = flag_c_i;
    end else if (funct_i == FUNCT_W'(BR_BNCY)) begin
      taken_c_o = ~flag_c_i;
    end else if (funct_i == FUNCT_W'(BR_BL)) begin
      taken_c_o = 1'b1;
      link_c_o  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the miniRISC ALU: IDLE -> EXEC -> WB, flag registers, WB strobes.
module alu_issue_ctrl
  import minirisc_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         op_class,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_sw,
  output logic               imm_sel,
  input  logic               alu_sign,
  input  logic               alu_zero,
  input  logic               alu_carry,
  output logic               flag_s,
  output logic               flag_z,
  output logic               flag_c,
  output logic               wb_en,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               branch_taken,
  output logic               link_en,
  output logic               illegal
);

  issue_state_e       state_q;
  logic               ready_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               alu_sw_q;
  logic               imm_sel_q;
  logic [2:0]         cls_q;
  logic [FUNCT_W-1:0] funct_q;
  logic               ill_q;
  logic               flag_s_q, flag_z_q, flag_c_q;
  logic               wb_en_q, mem_rd_q, mem_wr_q, br_q, link_q, ill_str_q;

  logic [ALUOP_W-1:0] dec_op_c;
  logic               dec_sw_c;
  logic               dec_imm_c;
  logic               dec_ill_c;
  logic               br_taken_c;
  logic               br_link_c;

  // Decode op_class/funct into ALU controls and legality
  always_comb begin
    dec_op_c  = ALUOP_W'(ALU_PASS);
    dec_sw_c  = 1'b0;
    dec_imm_c = 1'b0;
    dec_ill_c = 1'b0;
    case (op_class)
      OPC_ALU_R, OPC_ALU_I: begin
        dec_imm_c = (op_class == OPC_ALU_I);
        if      (funct == FUNCT_W'(FN_ADD))  dec_op_c = ALUOP_W'(ALU_ADDC);
        else if (funct == FUNCT_W'(FN_COMP)) begin
          dec_op_c = ALUOP_W'(ALU_ADD);
          dec_sw_c = 1'b1;
        end
        else if (funct == FUNCT_W'(FN_AND))  dec_op_c = ALUOP_W'(ALU_AND);
        else if (funct == FUNCT_W'(FN_XOR))  dec_op_c = ALUOP_W'(ALU_XOR);
        else if (funct == FUNCT_W'(FN_SHLL)) dec_op_c = ALUOP_W'(ALU_SHLL);
        else if (funct == FUNCT_W'(FN_SHRL)) dec_op_c = ALUOP_W'(ALU_SHRL);
        else if (funct == FUNCT_W'(FN_SHRA)) dec_op_c = ALUOP_W'(ALU_SHRA);
        else if (funct == FUNCT_W'(FN_DIFF)) dec_op_c = ALUOP_W'(ALU_DIFF);
        else                                 dec_ill_c = 1'b1;
      end
      OPC_MEM_LD, OPC_MEM_ST: begin
        dec_op_c  = ALUOP_W'(ALU_ADD);
        dec_imm_c = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ill_c = (funct > FUNCT_W'(BR_BL));
      end
      default: dec_ill_c = 1'b1;
    endcase
    // Illegal instructions present a fixed opcode with no operand muxing
    if (dec_ill_c) begin
      dec_op_c  = ALUOP_W'(ALU_ILL);
      dec_sw_c  = 1'b0;
      dec_imm_c = 1'b0;
    end
  end

  branch_cond #(.FUNCT_W(FUNCT_W)) u_branch_cond (
    .funct_i   (funct_q),
    .flag_s_i  (flag_s_q),
    .flag_z_i  (flag_z_q),
    .flag_c_i  (flag_c_q),
    .taken_c_o (br_taken_c),
    .link_c_o  (br_link_c)
  );

  // Issue FSM, held ALU controls, flag registers and one-cycle WB strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      alu_op_q  <= '0;
      alu_sw_q  <= 1'b0;
      imm_sel_q <= 1'b0;
      cls_q     <= '0;
      funct_q   <= '0;
      ill_q     <= 1'b0;
      flag_s_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      br_q      <= 1'b0;
      link_q    <= 1'b0;
      ill_str_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            state_q   <= ST_EXEC;
            ready_q   <= 1'b0;
            alu_op_q  <= dec_op_c;
            alu_sw_q  <= dec_sw_c;
            imm_sel_q <= dec_imm_c;
            cls_q     <= op_class;
            funct_q   <= funct;
            ill_q     <= dec_ill_c;
          end
        end
        ST_EXEC: begin
          state_q <= ST_WB;
          if (ill_q) begin
            ill_str_q <= 1'b1;
          end else begin
            case (cls_q)
              OPC_ALU_R, OPC_ALU_I: begin
                wb_en_q  <= 1'b1;
                flag_s_q <= alu_sign;
                flag_z_q <= alu_zero;
                if (alu_op_q == ALUOP_W'(ALU_ADDC)) flag_c_q <= alu_carry;
              end
              OPC_MEM_LD: begin
                mem_rd_q <= 1'b1;
                wb_en_q  <= 1'b1;
              end
              OPC_MEM_ST: mem_wr_q <= 1'b1;
              OPC_BRANCH: begin
                br_q   <= br_taken_c;
                link_q <= br_link_c;
              end
              default: ;
            endcase
          end
        end
        ST_WB: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          alu_op_q  <= '0;
          alu_sw_q  <= 1'b0;
          imm_sel_q <= 1'b0;
          wb_en_q   <= 1'b0;
          mem_rd_q  <= 1'b0;
          mem_wr_q  <= 1'b0;
          br_q      <= 1'b0;
          link_q    <= 1'b0;
          ill_str_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready  = ready_q;
  assign alu_op       = alu_op_q;
  assign alu_sw       = alu_sw_q;
  assign imm_sel      = imm_sel_q;
  assign flag_s       = flag_s_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign wb_en        = wb_en_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign branch_taken = br_q;
  assign link_en      = link_q;
  assign illegal      = ill_str_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: timeline model checked every cycle plus hand-computed literals.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] op_class = 3'd0;
  logic [3:0] funct = 4'd0;
  logic [3:0] alu_op;
  logic       alu_sw, imm_sel;
  logic       alu_sign = 1'b0, alu_zero = 1'b0, alu_carry = 1'b0;
  logic       flag_s, flag_z, flag_c;
  logic       wb_en, mem_rd, mem_wr, branch_taken, link_en, illegal;

  int checks = 0;
  int failures = 0;
  logic run_chk = 1'b0;

  alu_issue_ctrl #(.ALUOP_W(4), .FUNCT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_class(op_class), .funct(funct),
    .alu_op(alu_op), .alu_sw(alu_sw), .imm_sel(imm_sel),
    .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c),
    .wb_en(wb_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .branch_taken(branch_taken), .link_en(link_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_age: -1 no instruction in flight, 0 = first cycle after accept, 1 = write-back cycle
  int         m_age;
  logic [2:0] m_cls;
  logic [3:0] m_fn;
  logic       m_fs, m_fz, m_fc;

  function automatic logic legal(input logic [2:0] c, input logic [3:0] f);
    if (c <= 3'd1) return f <= 4'd7;
    if (c == 3'd2 || c == 3'd3) return 1'b1;
    if (c == 3'd4) return f <= 4'd6;
    return 1'b0;
  endfunction

  // {alu_op, alu_sw, imm_sel} an accepted instruction must present
  function automatic logic [5:0] ctl(input logic [2:0] c, input logic [3:0] f);
    logic [3:0] tbl [8];
    tbl = '{4'b0001, 4'b1000, 4'b0010, 4'b0011, 4'b0110, 4'b0100, 4'b0101, 4'b1001};
    if (!legal(c, f)) return {4'b1111, 1'b0, 1'b0};
    if (c <= 3'd1)    return {tbl[f[2:0]], f == 4'd1, c == 3'd1};
    if (c == 3'd4)    return 6'b0;
    return {4'b1000, 1'b0, 1'b1};
  endfunction

  function automatic logic br_cond(input logic [3:0] f, input logic s, input logic z, input logic cy);
    case (f)
      4'd0, 4'd6: return 1'b1;
      4'd1: return s;
      4'd2: return z;
      4'd3: return !z;
      4'd4: return cy;
      4'd5: return !cy;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= -1; m_cls <= 3'd0; m_fn <= 4'd0;
      m_fs <= 1'b0; m_fz <= 1'b0; m_fc <= 1'b0;
    end else if (m_age < 0) begin
      if (instr_valid) begin
        m_age <= 0; m_cls <= op_class; m_fn <= funct;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
      if (legal(m_cls, m_fn) && m_cls <= 3'd1) begin
        m_fs <= alu_sign;
        m_fz <= alu_zero;
        if (m_fn == 4'd0) m_fc <= alu_carry;
      end
    end else begin
      m_age <= -1;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (run_chk) begin
      logic [5:0] c;
      logic       wb, ok, isalu;
      c     = (m_age >= 0) ? ctl(m_cls, m_fn) : 6'b0;
      wb    = (m_age == 1);
      ok    = legal(m_cls, m_fn);
      isalu = (m_cls <= 3'd1);
      chk("ready",   {3'b0, instr_ready}, {3'b0, m_age < 0});
      chk("alu_op",  alu_op, c[5:2]);
      chk("alu_sw",  {3'b0, alu_sw},  {3'b0, c[1]});
      chk("imm_sel", {3'b0, imm_sel}, {3'b0, c[0]});
      chk("flags",   {1'b0, flag_s, flag_z, flag_c}, {1'b0, m_fs, m_fz, m_fc});
      chk("wb_en",   {3'b0, wb_en},  {3'b0, wb && ok && (isalu || m_cls == 3'd2)});
      chk("mem_rd",  {3'b0, mem_rd}, {3'b0, wb && ok && m_cls == 3'd2});
      chk("mem_wr",  {3'b0, mem_wr}, {3'b0, wb && ok && m_cls == 3'd3});
      chk("branch",  {3'b0, branch_taken},
          {3'b0, wb && ok && m_cls == 3'd4 && br_cond(m_fn, m_fs, m_fz, m_fc)});
      chk("link",    {3'b0, link_en}, {3'b0, wb && ok && m_cls == 3'd4 && m_fn == 4'd6});
      chk("illegal", {3'b0, illegal}, {3'b0, wb && !ok});
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] cap_op;
  logic       cap_sw, cap_imm, cap_rdy_e, cap_rdy_w;
  logic       cap_wb, cap_rd, cap_wr, cap_br, cap_lk, cap_ill;

  // Issue one instruction from an idle negedge; returns at the negedge after WB
  task automatic issue(input logic [2:0] cls, input logic [3:0] fn,
                       input logic s, input logic z, input logic cy, input logic hold);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_wait", 4'd0, 4'd1);
    instr_valid = 1'b1; op_class = cls; funct = fn;
    alu_sign = s; alu_zero = z; alu_carry = cy;
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    cap_op = alu_op; cap_sw = alu_sw; cap_imm = imm_sel; cap_rdy_e = instr_ready;
    @(negedge clk);
    cap_wb = wb_en; cap_rd = mem_rd; cap_wr = mem_wr;
    cap_br = branch_taken; cap_lk = link_en; cap_ill = illegal; cap_rdy_w = instr_ready;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] alu_fns [3];
    logic [3:0] alu_ops [3];
    alu_fns = '{4'd3, 4'd6, 4'd7};
    alu_ops = '{4'b0011, 4'b0101, 4'b1001};

    repeat (2) @(negedge clk);
    run_chk = 1'b1;
    chk("rst_ready", {3'b0, instr_ready}, 4'd1);
    chk("rst_op", alu_op, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // add: sign=1, zero=0, carry=1
    issue(3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("add_op", cap_op, 4'b0001);
    chk("add_wb", {3'b0, cap_wb}, 4'd1);
    chk("add_flags", {1'b0, flag_s, flag_z, flag_c}, 4'b0101);

    // ALU_I comp with carry=0: flag_c retained
    issue(3'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("comp_ctl", {cap_op[3:2] == 2'b10 ? cap_op : 4'hx}, 4'b1000);
    chk("comp_sw_imm", {2'b0, cap_sw, cap_imm}, 4'b0011);
    chk("comp_fc", {3'b0, flag_c}, 4'd1);

    // load then store
    issue(3'd2, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ld_op", cap_op, 4'b1000);
    chk("ld_str", {2'b0, cap_rd, cap_wb}, 4'b0011);
    chk("ld_busy", {2'b0, cap_rdy_e, cap_rdy_w}, 4'd0);
    issue(3'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("st_str", {2'b0, cap_wr, cap_wb}, 4'b0010);
    chk("st_imm", {3'b0, cap_imm}, 4'd1);
    chk("mem_flags", {1'b0, flag_s, flag_z, flag_c}, 4'b0001);

    // other ALU functs, pick up zero=1 from the last (diff: not add, flag_c kept)
    for (int i = 0; i < 3; i++) begin
      issue(3'd0, alu_fns[i], 1'b0, i == 2, 1'b0, 1'b0);
      chk("alu_tbl", cap_op, alu_ops[i]);
    end
    chk("z_set_flags", {1'b0, flag_s, flag_z, flag_c}, 4'b0011);

    // branches on s=0 z=1 c=1
    issue(3'd4, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bz", {2'b0, cap_br, cap_lk}, 4'b0010);
    issue(3'd4, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bnz", {3'b0, cap_br}, 4'd0);
    issue(3'd4, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bl", {2'b0, cap_br, cap_lk}, 4'b0011);
    issue(3'd4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bncy", {3'b0, cap_br}, 4'd0);
    issue(3'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bcy", {3'b0, cap_br}, 4'd1);
    issue(3'd4, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bltz", {3'b0, cap_br}, 4'd0);
    issue(3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b", {3'b0, cap_br}, 4'd1);

    // illegal instructions, valid held through EXEC/WB
    issue(3'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ill_cls_op", cap_op, 4'b1111);
    chk("ill_cls_str", {2'b0, cap_ill, cap_wb}, 4'b0010);
    chk("ill_norestart", {3'b0, instr_ready}, 4'd1);
    issue(3'd0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ill_fn_op", cap_op, 4'b1111);
    chk("ill_fn_str", {2'b0, cap_ill, cap_wb}, 4'b0010);
    issue(3'd4, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ill_br", {2'b0, cap_ill, cap_br}, 4'b0010);
    chk("ill_flags", {1'b0, flag_s, flag_z, flag_c}, 4'b0011);

    // reset mid-EXEC of an add
    instr_valid = 1'b1; op_class = 3'd0; funct = 4'd0;
    alu_sign = 1'b1; alu_zero = 1'b0; alu_carry = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("pre_rst_op", alu_op, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_op", alu_op, 4'd0);
    chk("rst_mid_ready", {3'b0, instr_ready}, 4'd1);
    chk("rst_mid_flags", {1'b0, flag_s, flag_z, flag_c}, 4'd0);
    @(negedge clk);
    chk("rst_mid_wb", {3'b0, wb_en}, 4'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {3'b0, instr_ready}, 4'd1);
    @(negedge clk);

    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
